// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/write-back
// with a configurable memory wait, illegal-opcode flagging and a retire counter.
module mc_controller #(
    parameter int MEM_LAT = 0,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       Fu,
    input  logic             zero,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [1:0]       PCSrc,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic             ALUSrc,
    output logic [2:0]       ALUOp,
    output logic             EXTOp,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_WBMEM  = 4'd4,  S_MEMWR  = 4'd5,  S_EXER   = 4'd6,  S_EXEI  = 4'd7,
        S_WBALU  = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JR    = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_LW, C_SW, C_ADDU, C_SUBU, C_ORI, C_LUI, C_BEQ, C_JAL, C_JR, C_ILL
    } class_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t           state_reg, state_next;
    class_t           class_reg, class_next, decoded;
    logic [3:0]       wait_reg, wait_next;
    logic [CNT_W-1:0] retired_reg;
    logic             wait_done;
    logic             retire;
    logic             unused;

    // The branch condition is resolved in the datapath; the controller only strobes.
    assign unused    = zero;
    assign wait_done = (wait_reg == LAT);
    assign state     = state_reg;
    assign retired   = retired_reg;

    always_comb begin
        decoded = C_ILL;
        case (op)
            6'b000000: begin
                case (Fu)
                    6'b100001: decoded = C_ADDU;
                    6'b100011: decoded = C_SUBU;
                    6'b001000: decoded = C_JR;
                    default:   decoded = C_ILL;
                endcase
            end
            6'b100011: decoded = C_LW;
            6'b101011: decoded = C_SW;
            6'b001101: decoded = C_ORI;
            6'b001111: decoded = C_LUI;
            6'b000100: decoded = C_BEQ;
            6'b000011: decoded = C_JAL;
            default:   decoded = C_ILL;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        class_next = class_reg;
        case (state_reg)
            S_FETCH:  if (wait_done) state_next = S_DECODE;
            S_DECODE: begin
                class_next = decoded;
                case (decoded)
                    C_LW, C_SW:     state_next = S_MEMADR;
                    C_ADDU, C_SUBU: state_next = S_EXER;
                    C_ORI, C_LUI:   state_next = S_EXEI;
                    C_BEQ:          state_next = S_BRANCH;
                    C_JAL:          state_next = S_JAL;
                    C_JR:           state_next = S_JR;
                    default:        state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = (class_reg == C_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (wait_done) state_next = S_WBMEM;
            S_MEMWR:  if (wait_done) state_next = S_FETCH;
            S_EXER:   state_next = S_WBALU;
            S_EXEI:   state_next = S_WBALU;
            default:  state_next = S_FETCH;
        endcase
    end

    // Only the waiting states ever hold, so holding means "count one more cycle".
    assign wait_next = (state_next == state_reg) ? wait_reg + 4'd1 : 4'd0;
    assign retire    = (state_next == S_FETCH) &&
                       (state_reg inside {S_WBMEM, S_MEMWR, S_WBALU, S_BRANCH, S_JAL, S_JR});

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= S_FETCH;
            class_reg   <= C_NONE;
            wait_reg    <= 4'd0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            class_reg <= class_next;
            wait_reg  <= wait_next;
            if (retire) retired_reg <= retired_reg + CNT_W'(1);
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSrc       = 2'b00;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUSrc      = 1'b0;
        ALUOp       = 3'b000;
        EXTOp       = 1'b0;
        illegal     = 1'b0;
        if (reset) begin
            case (state_reg)
                S_FETCH: begin
                    IRWrite = wait_done;
                    PCWrite = wait_done;
                end
                S_DECODE: illegal = (decoded == C_ILL);
                S_MEMADR: begin
                    ALUSrc = 1'b1;
                    ALUOp  = 3'b010;
                end
                S_MEMRD: MemRead = 1'b1;
                S_WBMEM: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'b01;
                end
                S_MEMWR: MemWrite = 1'b1;
                S_EXER:  ALUOp = (class_reg == C_SUBU) ? 3'b011 : 3'b010;
                S_EXEI: begin
                    ALUSrc = 1'b1;
                    if (class_reg == C_LUI) begin
                        ALUOp = 3'b111;
                    end else begin
                        ALUOp = 3'b001;
                        EXTOp = 1'b1;
                    end
                end
                S_WBALU: begin
                    RegWrite = 1'b1;
                    if (class_reg == C_ADDU || class_reg == C_SUBU) RegDst = 2'b01;
                    if (class_reg == C_LUI) MemtoReg = 2'b10;
                end
                S_BRANCH: begin
                    ALUOp       = 3'b011;
                    PCWriteCond = 1'b1;
                    PCSrc       = 2'b01;
                end
                S_JAL: begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b11;
                    PCWrite  = 1'b1;
                    PCSrc    = 2'b10;
                end
                S_JR: begin
                    PCWrite = 1'b1;
                    PCSrc   = 2'b11;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench: two controllers (MEM_LAT=0/CNT_W=32 and MEM_LAT=3/CNT_W=4) checked
// cycle by cycle against per-instruction step scripts built from the instruction rules.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        zero = 1'b0;
    logic        reset_a [2];
    logic [5:0]  op_a [2];
    logic [5:0]  fu_a [2];
    wire  [17:0] cv0, cv1;
    wire  [3:0]  st0, st1;
    wire  [31:0] ret0;
    wire  [3:0]  ret1;

    int checks = 0;
    int failures = 0;
    int cur = 0;
    int ret_model = 0;

    always #5 clk = ~clk;

    // Packed control view: {PCWrite, PCWriteCond, PCSrc, IRWrite, MemRead, MemWrite,
    // RegWrite, RegDst, MemtoReg, ALUSrc, ALUOp, EXTOp, illegal}
    mc_controller #(.MEM_LAT(0), .CNT_W(32)) u0 (
        .clk(clk), .reset(reset_a[0]), .op(op_a[0]), .Fu(fu_a[0]), .zero(zero),
        .PCWrite(cv0[17]), .PCWriteCond(cv0[16]), .PCSrc(cv0[15:14]), .IRWrite(cv0[13]),
        .MemRead(cv0[12]), .MemWrite(cv0[11]), .RegWrite(cv0[10]), .RegDst(cv0[9:8]),
        .MemtoReg(cv0[7:6]), .ALUSrc(cv0[5]), .ALUOp(cv0[4:2]), .EXTOp(cv0[1]),
        .state(st0), .illegal(cv0[0]), .retired(ret0)
    );

    mc_controller #(.MEM_LAT(3), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset_a[1]), .op(op_a[1]), .Fu(fu_a[1]), .zero(zero),
        .PCWrite(cv1[17]), .PCWriteCond(cv1[16]), .PCSrc(cv1[15:14]), .IRWrite(cv1[13]),
        .MemRead(cv1[12]), .MemWrite(cv1[11]), .RegWrite(cv1[10]), .RegDst(cv1[9:8]),
        .MemtoReg(cv1[7:6]), .ALUSrc(cv1[5]), .ALUOp(cv1[4:2]), .EXTOp(cv1[1]),
        .state(st1), .illegal(cv1[0]), .retired(ret1)
    );

    localparam logic [17:0] PCW = 18'h20000, PCWC = 18'h10000, IRW = 18'h02000;
    localparam logic [17:0] MR = 18'h01000, MW = 18'h00800, RW = 18'h00400;
    localparam logic [17:0] ALUS = 18'h00020, EXT = 18'h00002, ILL = 18'h00001;

    function automatic logic [17:0] pcsrc(input logic [1:0] v); return {2'b0, v, 14'b0}; endfunction
    function automatic logic [17:0] rdst(input logic [1:0] v);  return {8'b0, v, 8'b0}; endfunction
    function automatic logic [17:0] mtr(input logic [1:0] v);   return {10'b0, v, 6'b0}; endfunction
    function automatic logic [17:0] aop(input logic [2:0] v);   return {13'b0, v, 2'b0}; endfunction

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] c;
    } step_t;

    step_t script[$];
    string kind_name [10] = '{"lw", "sw", "addu", "subu", "ori", "lui", "beq", "jal", "jr", "illegal"};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%h exp=%h t=%0t", tag, cur, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] cur_ctrl();
        return (cur == 0) ? cv0 : cv1;
    endfunction
    function automatic logic [3:0] cur_state();
        return (cur == 0) ? st0 : st1;
    endfunction
    function automatic logic [31:0] cur_ret();
        return (cur == 0) ? ret0 : {28'b0, ret1};
    endfunction
    function automatic int cur_lat();
        return (cur == 0) ? 0 : 3;
    endfunction
    function automatic logic [31:0] ret_expect();
        return (cur == 0) ? 32'(ret_model) : 32'(ret_model % 16);
    endfunction

    task automatic push(input logic [3:0] st, input logic [17:0] c);
        script.push_back('{st: st, c: c});
    endtask

    task automatic build(input int k, input int L);
        script.delete();
        for (int i = 0; i <= L; i++) push(4'd0, (i == L) ? (IRW | PCW) : 18'h0);
        push(4'd1, (k == 9) ? ILL : 18'h0);
        case (k)
            0: begin
                push(4'd2, ALUS | aop(3'b010));
                for (int i = 0; i <= L; i++) push(4'd3, MR);
                push(4'd4, RW | mtr(2'b01));
            end
            1: begin
                push(4'd2, ALUS | aop(3'b010));
                for (int i = 0; i <= L; i++) push(4'd5, MW);
            end
            2: begin push(4'd6, aop(3'b010)); push(4'd8, RW | rdst(2'b01)); end
            3: begin push(4'd6, aop(3'b011)); push(4'd8, RW | rdst(2'b01)); end
            4: begin push(4'd7, ALUS | aop(3'b001) | EXT); push(4'd8, RW); end
            5: begin push(4'd7, ALUS | aop(3'b111)); push(4'd8, RW | mtr(2'b10)); end
            6: push(4'd9, aop(3'b011) | PCWC | pcsrc(2'b01));
            7: push(4'd10, RW | rdst(2'b10) | mtr(2'b11) | PCW | pcsrc(2'b10));
            8: push(4'd11, PCW | pcsrc(2'b11));
            default: ;
        endcase
    endtask

    task automatic encode(input int k, output logic [5:0] o, output logic [5:0] f);
        f = 6'($urandom);
        case (k)
            0: o = 6'b100011;
            1: o = 6'b101011;
            2: begin o = 6'b000000; f = 6'b100001; end
            3: begin o = 6'b000000; f = 6'b100011; end
            4: o = 6'b001101;
            5: o = 6'b001111;
            6: o = 6'b000100;
            7: o = 6'b000011;
            8: begin o = 6'b000000; f = 6'b001000; end
            default: begin
                case ($urandom_range(0, 2))
                    0: o = 6'b111111;
                    1: begin o = 6'b000000; f = 6'b100000; end
                    default: o = 6'b001000;
                endcase
            end
        endcase
    endtask

    // Called at posedge+1; leaves time at posedge+1 of the following cycle.
    task automatic do_cycle(input step_t s, input bit is_dec, input logic [5:0] o, input logic [5:0] f);
        op_a[cur] = is_dec ? o : 6'($urandom);
        fu_a[cur] = is_dec ? f : 6'($urandom);
        zero = 1'($urandom);
        #1;
        chk("state", 32'(cur_state()), 32'(s.st));
        chk("ctrl", 32'(cur_ctrl()), 32'(s.c));
        @(posedge clk);
        #1;
    endtask

    task automatic mid_reset();
        reset_a[cur] = 1'b0;
        #1;
        chk("rst_ctrl_async", 32'(cur_ctrl()), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_state", 32'(cur_state()), 32'h0);
        chk("rst_retired", cur_ret(), 32'h0);
        chk("rst_ctrl", 32'(cur_ctrl()), 32'h0);
        reset_a[cur] = 1'b1;
        ret_model = 0;
        $display("inst%0d reset asserted mid-instruction, retired_model=0", cur);
    endtask

    task automatic run_instr(input int k, input int rst_at);
        logic [5:0] o, f;
        int L;
        L = cur_lat();
        build(k, L);
        encode(k, o, f);
        for (int i = 0; i < script.size(); i++) begin
            if (i == rst_at) begin
                mid_reset();
                return;
            end
            do_cycle(script[i], (i == L + 1), o, f);
        end
        if (k != 9) ret_model++;
        chk("retired", cur_ret(), ret_expect());
        $display("inst%0d %s op=%b fu=%b cycles=%0d retired=%0d", cur, kind_name[k], o, f,
                 script.size(), cur_ret());
    endtask

    initial begin
        int directed0 [10] = '{2, 0, 1, 6, 7, 8, 9, 4, 5, 3};
        reset_a[0] = 1'b0;
        reset_a[1] = 1'b0;
        op_a[0] = 6'd0; fu_a[0] = 6'd0;
        op_a[1] = 6'd0; fu_a[1] = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            cur = i;
            chk("init_ctrl", 32'(cur_ctrl()), 32'h0);
            chk("init_state", 32'(cur_state()), 32'h0);
            chk("init_retired", cur_ret(), 32'h0);
        end

        cur = 0;
        ret_model = 0;
        reset_a[0] = 1'b1;
        foreach (directed0[i]) run_instr(directed0[i], -1);
        repeat (30) run_instr(int'($urandom_range(0, 9)), -1);

        cur = 1;
        ret_model = 0;
        reset_a[1] = 1'b1;
        run_instr(2, -1);
        run_instr(4, -1);
        run_instr(0, cur_lat() + 4);
        repeat (17) run_instr(int'($urandom_range(0, 8)), -1);
        chk("wrap17", cur_ret(), 32'd1);
        for (int k = 0; k < 10; k++) run_instr(k, -1);
        repeat (20) run_instr(int'($urandom_range(0, 9)), -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout inst=%0d", cur);
        $fatal(1, "timeout");
    end

endmodule
